// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: scans a framebuffer and drives 640x480@60 VGA timing with centred greyscale image.
// Revision: 1.0
`default_nettype none

module vga_frame_scanner #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X0       = 192,
  parameter int unsigned Y0       = 112,
  parameter int unsigned ADDR_W   = 16,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              vgaclk,
  output logic              hsync,
  output logic              vsync,
  output logic              sync_b,
  output logic              blank_b,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_start
);

  localparam int unsigned LOG_W = $clog2(IMG_W);
  localparam int unsigned LOG_H = $clog2(IMG_H);

  localparam logic [9:0] c_H_ACT    = 10'd640;
  localparam logic [9:0] c_H_SYNC_S = 10'd656;
  localparam logic [9:0] c_H_SYNC_E = 10'd752;
  localparam logic [9:0] c_H_LAST   = 10'd799;
  localparam logic [9:0] c_V_ACT    = 10'd480;
  localparam logic [9:0] c_V_SYNC_S = 10'd490;
  localparam logic [9:0] c_V_SYNC_E = 10'd492;
  localparam logic [9:0] c_V_LAST   = 10'd524;
  localparam logic [9:0] c_X_LO     = 10'(X0);
  localparam logic [9:0] c_X_HI     = 10'(X0 + IMG_W);
  localparam logic [9:0] c_Y_LO     = 10'(Y0);
  localparam logic [9:0] c_Y_HI     = 10'(Y0 + IMG_H);

  logic              phase_q;
  logic [9:0]        hcnt_q, hcnt_d;
  logic [9:0]        vcnt_q, vcnt_d;

  logic              s1_in_img_q;
  logic              s1_hs_q;
  logic              s1_vs_q;
  logic              s1_act_q;
  logic              s1_first_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              hsync_q;
  logic              vsync_q;
  logic              blank_b_q;
  logic [7:0]        pix_q;
  logic              frame_start_q;

  logic              w_in_img;
  logic              w_hs_on;
  logic              w_vs_on;
  logic              w_act;
  logic              w_first;
  logic [LOG_W-1:0]  w_xoff;
  logic [LOG_H-1:0]  w_yoff;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_pix;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == c_H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == c_V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  assign w_in_img = (hcnt_q >= c_X_LO) && (hcnt_q < c_X_HI) &&
                    (vcnt_q >= c_Y_LO) && (vcnt_q < c_Y_HI);
  assign w_hs_on  = (hcnt_q >= c_H_SYNC_S) && (hcnt_q < c_H_SYNC_E);
  assign w_vs_on  = (vcnt_q >= c_V_SYNC_S) && (vcnt_q < c_V_SYNC_E);
  assign w_act    = (hcnt_q < c_H_ACT) && (vcnt_q < c_V_ACT);
  assign w_first  = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);

  // Image dimensions are powers of two, so the offsets simply truncate into the address fields.
  assign w_xoff = LOG_W'(hcnt_q - c_X_LO);
  assign w_yoff = LOG_H'(vcnt_q - c_Y_LO);
  assign w_addr = w_in_img ? ADDR_W'({w_yoff, w_xoff}) : '0;

  always_comb begin
    w_pix = 8'h00;
    if (s1_act_q) begin
      w_pix = (s1_in_img_q && display_en) ? mem_data : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= 1'b0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      s1_in_img_q   <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_act_q      <= 1'b0;
      s1_first_q    <= 1'b0;
      mem_addr_q    <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_b_q     <= 1'b0;
      pix_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= ~phase_q;
      frame_start_q <= 1'b0;
      // Pixel state moves only while vgaclk is high, so every output changes on its falling edge.
      if (phase_q) begin
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        s1_in_img_q   <= w_in_img;
        s1_hs_q       <= w_hs_on;
        s1_vs_q       <= w_vs_on;
        s1_act_q      <= w_act;
        s1_first_q    <= w_first;
        mem_addr_q    <= w_addr;
        hsync_q       <= ~s1_hs_q;
        vsync_q       <= ~s1_vs_q;
        blank_b_q     <= s1_act_q;
        pix_q         <= w_pix;
        frame_start_q <= s1_first_q;
      end
    end
  end

  assign vgaclk      = phase_q;
  assign mem_addr    = mem_addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_b      = 1'b0;
  assign blank_b     = blank_b_q;
  assign r           = pix_q;
  assign g           = pix_q;
  assign b           = pix_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: randomized display_en / reset stimulus checked against a time-based VGA model.
`default_nettype none

module tb_vga_frame_scanner;

  localparam int          IMG_W  = 256;
  localparam int          IMG_H  = 8;
  localparam int          X0     = 192;
  localparam int          Y0     = 2;
  localparam int          ADDR_W = 11;
  localparam logic [7:0]  BG     = 8'hA5;
  localparam int          LINE   = 800;
  localparam int          FRAME  = 800 * 525;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              display_en = 1'b1;
  logic [7:0]        mem_data   = 8'h00;
  logic [ADDR_W-1:0] mem_addr;
  logic              vgaclk, hsync, vsync, sync_b, blank_b, frame_start;
  logic [7:0]        r, g, b;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  int   n_checks = 0;
  int   n_errors = 0;
  int   t        = 0;
  logic en_m     = 1'b1;
  int   hs_run   = 0;
  int   bl_run   = 0;
  logic hs_prev  = 1'b1;
  logic bl_prev  = 1'b0;

  vga_frame_scanner #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .X0      (X0),
    .Y0      (Y0),
    .ADDR_W  (ADDR_W),
    .BG_COLOR(BG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .display_en (display_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .vgaclk     (vgaclk),
    .hsync      (hsync),
    .vsync      (vsync),
    .sync_b     (sync_b),
    .blank_b    (blank_b),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer: data follows the address one clk later.
  always @(posedge clk) mem_data <= ram[mem_addr];

  function automatic int addr_of(input int p);
    int h, v;
    h = p % LINE;
    v = p / LINE;
    if (h >= X0 && h < X0 + IMG_W && v >= Y0 && v < Y0 + IMG_H)
      return (v - Y0) * IMG_W + (h - X0);
    return 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // t counts clk edges since reset was released (0 = the edge that applied reset).
  task automatic step();
    logic r_s, e_s;
    int   p, h, v, a;
    int   e_hs, e_vs, e_bl, e_pix, e_fs;
    bit   act, img;
    r_s = rst;
    e_s = display_en;
    @(posedge clk);
    if (r_s) t = 0;
    else     t = t + 1;
    if (!r_s && (t % 2 == 0)) en_m = e_s;
    #1;
    e_hs = 1; e_vs = 1; e_bl = 0; e_pix = 0; e_fs = 0;
    if (t >= 4) begin
      p    = ((t - 4) / 2) % FRAME;
      h    = p % LINE;
      v    = p / LINE;
      act  = (h < 640) && (v < 480);
      img  = (h >= X0) && (h < X0 + IMG_W) && (v >= Y0) && (v < Y0 + IMG_H);
      a    = addr_of(p);
      e_hs = (h >= 656 && h < 752) ? 0 : 1;
      e_vs = (v >= 490 && v < 492) ? 0 : 1;
      e_bl = act ? 1 : 0;
      e_pix = !act ? 0 : ((img && en_m) ? int'(ram[a]) : int'(BG));
      e_fs = ((t - 4) % (2 * FRAME) == 0) ? 1 : 0;
    end
    check("vgaclk",      vgaclk,      t % 2);
    check("sync_b",      sync_b,      0);
    check("mem_addr",    mem_addr,    (t >= 2) ? addr_of(((t - 2) / 2) % FRAME) : 0);
    check("hsync",       hsync,       e_hs);
    check("vsync",       vsync,       e_vs);
    check("blank_b",     blank_b,     e_bl);
    check("r",           r,           e_pix);
    check("g",           g,           e_pix);
    check("b",           b,           e_pix);
    check("frame_start", frame_start, e_fs);
    if (r_s) begin
      hs_run = 0; bl_run = 0; hs_prev = 1'b1; bl_prev = 1'b0;
    end else begin
      if (!hsync) hs_run++;
      else begin
        if (!hs_prev) check("hs_width", hs_run, 192);
        hs_run = 0;
      end
      if (blank_b) bl_run++;
      else begin
        if (bl_prev) check("blank_width", bl_run, 1280);
        bl_run = 0;
      end
      hs_prev = hsync;
      bl_prev = blank_b;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
    rst        = 1'b1;
    display_en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 12 * 2 * LINE; i++) begin
      step();
      if ($urandom_range(0, 699) == 0) display_en = ~display_en;
    end
    repeat ($urandom_range(0, 2 * LINE - 1)) step();
    rst = 1'b1;
    step();
    rst        = 1'b0;
    display_en = 1'b1;
    for (int i = 0; i < 13 * 2 * LINE; i++) begin
      step();
      if ($urandom_range(0, 699) == 0) display_en = ~display_en;
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Display back end that consumes the processor's result image: scans a framebuffer RAM and produces 640x480@60 Hz VGA timing plus 8-bit RGB for the board DAC.
- Runs on the 50 MHz system clock and derives the 25 MHz pixel rate internally.
- Centres an IMG_W x IMG_H greyscale image on screen and paints BG_COLOR everywhere else in the active area.

Parameters:
- IMG_W, 256, image width in pixels; must be a power of two.
- IMG_H, 256, image height in lines; must be a power of two.
- X0, 192, first active column of the image.
- Y0, 112, first active line of the image.
- ADDR_W, 16, framebuffer address width; must be at least log2(IMG_W*IMG_H).
- BG_COLOR, 8'h00, grey level for active pixels outside the image or when disabled.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- display_en  in  1  1 = show image, 0 = whole active area shows BG_COLOR.
- mem_addr  out  ADDR_W  framebuffer read address.
- mem_data  in  8  framebuffer read data; valid 1 clk after mem_addr changes and held until the next change.
- vgaclk  out  1  pixel clock, clk/2.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- sync_b  out  1  DAC composite sync; tied to constant 0.
- blank_b  out  1  1 during the active video area.
- r, g, b  out  8 each  pixel colour; all three carry the same value (greyscale).
- frame_start  out  1  one-clk pulse when the output pixel (0,0) is launched.

Behaviour:
- Phase: a phase register toggles every clk and drives vgaclk directly. An "update edge" is a clk edge where phase==1; every pixel-state register changes only on update edges, so all outputs change as vgaclk falls.
- Counters: hcnt 0..799 and vcnt 0..524. hcnt wraps 799->0, and on that wrap vcnt increments. vcnt wraps 524->0 on the same edge that hcnt wraps.
- Horizontal timing: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Stage 1 (update edge N), registered from the current counters:
  - in_img = (X0 <= hcnt < X0+IMG_W) and (Y0 <= vcnt < Y0+IMG_H).
  - mem_addr = {vcnt-Y0, hcnt-X0}, the low log2 bits of each field concatenated, when in_img; otherwise 0.
  - Also registered: hs_d, vs_d, act_d.
- Stage 2 (update edge N+1):
  - hsync, vsync, blank_b take stage-1 values.
  - r=g=b = mem_data if act_d and in_img_d and display_en; BG_COLOR if act_d and not (in_img_d and display_en); 0 when not act_d.
  - display_en is sampled on this edge only.
- Latency: the pixel at counter (h,v) appears on the outputs exactly 1 pixel (2 clk) after the counters held (h,v). Syncs and colour stay aligned.
- Memory read: at least 1 clk after the stage-1 edge. mem_data is sampled only at the stage-2 edge.
- frame_start: high for the single clk following the stage-2 edge that outputs pixel (0,0); period 840000 clk.
- Reset (synchronous, wins over everything):
  - phase=0, hcnt=0, vcnt=0, all pipeline registers cleared.
  - Outputs: vgaclk=0, hsync=1, vsync=1, blank_b=0, r=g=b=0, mem_addr=0, frame_start=0.
  - The first update edge is the 2nd clk after rst falls.
  - Reset asserted mid-frame restarts at (0,0) with no partial sync pulse carried over.

Test Plan:
- Reset release: hold rst 3 clk, then release. Expect every output at its reset value during rst. vgaclk first rises 1 clk after release. First frame_start occurs after the output of pixel (0,0), 4 clk after release.
- Horizontal sync: count hsync-low vgaclk periods per line. Expect exactly 96 periods, with the fall starting 656 pixels after the start of line output, and blank_b high for 640 pixels per active line.
- Vertical sync: vsync low for exactly 2 lines (1600 pixels), beginning 490 lines after frame_start. blank_b stays 0 for lines 480..524.
- Image path: RAM model returns mem_data = low byte of address. Expect r=g=b=8'h00 at output pixel (192,112) and 8'h05 at (197,113) (addr 0x0105). Expect BG_COLOR at (191,112) and at (448,112).
- display_en: deassert mid-line at pixel (300,200). From the next output pixel on, expect BG_COLOR inside the image; the image returns on the pixel after reassertion. Syncs are unaffected.
- Mid-frame reset: assert rst at counter (400,300) for 1 clk. Expect outputs at reset values on the next clk, and the frame restarting with frame_start 4 clk after release. The following frame_start interval is exactly 840000 clk.
